// File: rtl/i2c_regbank_pkg.sv
// Shared types and constants for the I2C slave register bank.
// Holds the FSM state encoding, ACK/NACK bus levels and the general-call address.
// No logic; imported by the top level.
package i2c_regbank_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    // SDA level during the acknowledge bit
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // Reserved general-call address, never acknowledged
    localparam logic [6:0] GENERAL_CALL = 7'h00;

endpackage

// File: rtl/i2c_slave_regbank_filter.sv
// Pin conditioner: 2-flop synchroniser, FILT-cycle agreement filter, edge pulses.
// Latency: filtered level and rise/fall pulse appear 2+FILT+1 clk cycles after the pin changes.
// No backpressure; one-cycle rise/fall pulses are registered outputs.
module i2c_in_filter #(
    parameter int FILT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic            r_s1;
    logic            r_s2;
    logic [FILT-1:0] r_hist;
    logic [FILT-1:0] w_hist_next;
    logic            r_lvl;
    logic            r_rise;
    logic            r_fall;

    // History of synchronised samples, newest in bit 0
    if (FILT == 1) begin : g_hist1
        assign w_hist_next = r_s2;
    end else begin : g_histn
        assign w_hist_next = {r_hist[FILT-2:0], r_s2};
    end

    // Synchronise, then only move the filtered level once FILT samples agree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_hist <= '1;
            r_lvl  <= 1'b1;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_pin;
            r_s2   <= r_s1;
            r_hist <= w_hist_next;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if ((&r_hist) && !r_lvl) begin
                r_lvl  <= 1'b1;
                r_rise <= 1'b1;
            end else if (!(|r_hist) && r_lvl) begin
                r_lvl  <= 1'b0;
                r_fall <= 1'b1;
            end
        end
    end

    assign o_lvl  = r_lvl;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/i2c_slave_regbank.sv
// 7-bit I2C target exposing N_OUT R/W output registers and N_IN RO input snapshots via an auto-incrementing pointer.
// Latency: register write/strobe one clk after the sampled last data bit; SDA changes one clk after a detected SCL fall.
// No clock stretching; optional SCL-low watchdog enabled by I2C_REGBANK_TIMEOUT_EN.
module i2c_slave_regbank
    import i2c_regbank_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR  = 7'h48,
    parameter int         N_OUT     = 4,
    parameter int         N_IN      = 4,
    parameter logic [7:0] OUT_RESET = 8'h00,
    parameter int         FILT      = 3
`ifdef I2C_REGBANK_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1200000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    inout  wire                  sda,
    input  logic                 scl,
    output logic [8*N_OUT-1:0]   out_regs,
    input  logic [8*N_IN-1:0]    in_regs,
    output logic [N_OUT-1:0]     wr_strobe,
    output logic                 busy
);

    localparam int         TOTAL    = N_OUT + N_IN;
    localparam logic [7:0] PTR_LAST = 8'(TOTAL - 1);

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_timeout, w_match;
    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;
    logic [7:0] w_ptr_next;

    state_t              r_state;
    logic [3:0]          r_bitcnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_ptr;
    logic                r_sda_oe;
    logic                r_busy;
    logic                r_rd;
    logic                r_mnack;
    logic [8*N_OUT-1:0]  r_out;
    logic [8*N_IN-1:0]   r_snap;
    logic [N_OUT-1:0]    r_strobe;

    i2c_in_filter #(.FILT(FILT)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (scl),
        .o_lvl  (w_scl_lvl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    i2c_in_filter #(.FILT(FILT)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (sda),
        .o_lvl  (w_sda_lvl),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    // Open-drain: only ever pull low or release
    assign sda = r_sda_oe ? 1'b0 : 1'bz;

    // Both pins share the filter latency, so the SCL level is aligned with SDA edges
    assign w_start    = w_sda_fall && w_scl_lvl;
    assign w_stop     = w_sda_rise && w_scl_lvl;
    assign w_byte     = {r_shift[6:0], w_sda_lvl};
    assign w_match    = (r_shift[7:1] == I2C_ADDR) && (r_shift[7:1] != GENERAL_CALL);
    assign w_ptr_next = (r_ptr == PTR_LAST) ? 8'h00 : r_ptr + 8'd1;

    // Read mux: output registers, then the input snapshot, zero above the map
    always_comb begin
        w_rd_byte = 8'h00;
        for (int k = 0; k < N_OUT; k++) begin
            if (r_ptr == 8'(k)) w_rd_byte = r_out[8*k +: 8];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (r_ptr == 8'(N_OUT + k)) w_rd_byte = r_snap[8*k +: 8];
        end
    end

`ifdef I2C_REGBANK_TIMEOUT_EN
    logic [23:0] r_tcnt;

    assign w_timeout = r_busy && !w_scl_lvl && (r_tcnt == TIMEOUT_CYC - 24'd1);

    // Watchdog counts SCL-low time while the bank owns a transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (!r_busy || w_scl_rise) begin
            r_tcnt <= '0;
        end else if (!w_scl_lvl && !w_timeout) begin
            r_tcnt <= r_tcnt + 24'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Protocol FSM: bus conditions first, then per-state SCL edge handling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_ptr    <= '0;
            r_sda_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_rd     <= 1'b0;
            r_mnack  <= NACK;
            r_out    <= {N_OUT{OUT_RESET}};
            r_snap   <= '0;
            r_strobe <= '0;
        end else begin
            r_strobe <= '0;
            if (w_stop) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                r_state  <= ADDR;
                r_bitcnt <= '0;
                r_sda_oe <= 1'b0;
            end else if (w_timeout) begin
                r_state  <= IDLE;
                r_bitcnt <= '0;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, PTR, WDATA: begin
                        if (w_scl_rise && (r_bitcnt < 4'd8)) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (r_bitcnt == 4'd7) begin
                                if (r_state == PTR) r_ptr <= w_byte;
                                if (r_state == WDATA) begin
                                    for (int k = 0; k < N_OUT; k++) begin
                                        if (r_ptr == 8'(k)) begin
                                            r_out[8*k +: 8] <= w_byte;
                                            r_strobe[k]     <= 1'b1;
                                        end
                                    end
                                    r_ptr <= w_ptr_next;
                                end
                            end
                        end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
                            r_bitcnt <= '0;
                            if (r_state == ADDR) begin
                                if (w_match) begin
                                    r_sda_oe <= 1'b1;
                                    r_busy   <= 1'b1;
                                    r_rd     <= r_shift[0];
                                    r_state  <= ADDR_ACK;
                                    if (r_shift[0]) r_snap <= in_regs;
                                end else begin
                                    r_sda_oe <= 1'b0;
                                    r_state  <= IGNORE;
                                end
                            end else begin
                                r_sda_oe <= 1'b1;
                                r_state  <= (r_state == PTR) ? PTR_ACK : WDATA_ACK;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bitcnt <= '0;
                            if (r_rd) begin
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                                r_ptr    <= w_ptr_next;
                                r_state  <= RDATA;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= PTR;
                            end
                        end
                    end
                    PTR_ACK, WDATA_ACK: begin
                        if (w_scl_fall) begin
                            r_bitcnt <= '0;
                            r_sda_oe <= 1'b0;
                            r_state  <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (w_scl_fall) begin
                            if (r_bitcnt < 4'd7) begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                                r_bitcnt <= r_bitcnt + 4'd1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= RDATA_ACK;
                            end
                        end
                    end
                    RDATA_ACK: begin
                        if (w_scl_rise) begin
                            r_mnack <= w_sda_lvl;
                        end else if (w_scl_fall) begin
                            r_bitcnt <= '0;
                            if (r_mnack == NACK) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= IGNORE;
                            end else begin
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                                r_ptr    <= w_ptr_next;
                                r_state  <= RDATA;
                            end
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_regs  = r_out;
    assign wr_strobe = r_strobe;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
module tb_i2c_slave_regbank;

    localparam int Q = 100;             // quarter SCL period (10 clk cycles)
    localparam logic [7:0] AW = 8'h90;  // 0x48 + W
    localparam logic [7:0] AR = 8'h91;  // 0x48 + R

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [31:0] in_regs = 32'h0;
    wire         sda;
    wire  [31:0] out_regs;
    wire  [3:0]  wr_strobe;
    wire         busy;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;

    always #5 clk = ~clk;

    i2c_slave_regbank #(
        .I2C_ADDR (7'h48),
        .N_OUT    (4),
        .N_IN     (4),
        .OUT_RESET(8'h00),
        .FILT     (3)
`ifdef I2C_REGBANK_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(24'd300)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sda      (sda),
        .scl      (m_scl),
        .out_regs (out_regs),
        .in_regs  (in_regs),
        .wr_strobe(wr_strobe),
        .busy     (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int scnt [4];
    bit busy_seen = 1'b0;
    int nack_cnt = 0;
    logic [7:0]  rd_buf [8];
    logic [31:0] m_out = 32'h0;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (wr_strobe[k] === 1'b1) scnt[k]++;
        if (busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clr_scnt();
        for (int k = 0; k < 4; k++) scnt[k] = 0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; #Q;
        m_scl = 1'b1; #Q;
        m_sda = 1'b1; #(2*Q);
    endtask

    task automatic tx_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; #Q;
            m_scl = 1'b1; #(2*Q);
            m_scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        ack = (sda === 1'b0);
        #Q;
        m_scl = 1'b0; #Q;
    endtask

    task automatic rx_byte(input bit mack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; m_scl = 1'b1;
            #Q; b[i] = sda;
            #Q; m_scl = 1'b0;
            #Q;
        end
        m_sda = mack ? 1'b0 : 1'b1; #Q;
        m_scl = 1'b1; #(2*Q);
        m_scl = 1'b0; #Q;
        m_sda = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        logic a;
        tx_byte(b, a);
        if (!a) nack_cnt++;
    endtask

    task automatic wr_txn(input logic [7:0] ptr, input logic [7:0] d);
        bus_start(); send(AW); send(ptr); send(d); bus_stop();
    endtask

    // Optional pointer load, repeated START, n-byte read; in_regs may change after byte 0
    task automatic rd_burst(input bit set_ptr, input logic [7:0] ptr, input int n,
                            input bit chg, input logic [31:0] newval);
        bus_start();
        if (set_ptr) begin
            send(AW); send(ptr); bus_start();
        end
        send(AR);
        for (int i = 0; i < n; i++) begin
            rx_byte(i < n - 1, rd_buf[i]);
            if (i == 0 && chg) in_regs = newval;
        end
        bus_stop();
    endtask

    typedef struct {
        logic [7:0] ptr;
        logic [7:0] wdat;
        logic [7:0] exp_rd;
        logic [3:0] exp_strb;
    } vec_t;

    vec_t vt [6];

    initial begin
        logic       a;
        logic [3:0] act_strb;
        int         p;

        vt[0] = '{8'h00, 8'h5A, 8'h5A, 4'b0001};
        vt[1] = '{8'h03, 8'hC3, 8'hC3, 4'b1000};
        vt[2] = '{8'h02, 8'h7E, 8'h7E, 4'b0100};
        vt[3] = '{8'h05, 8'hFF, 8'h66, 4'b0000};
        vt[4] = '{8'h07, 8'h00, 8'h88, 4'b0000};
        vt[5] = '{8'h20, 8'h99, 8'h00, 4'b0000};

        // Reset state
        #53;
        chk("rst_out_regs", out_regs, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_sda_released", {31'h0, sda}, 32'h1);
        rst = 1'b0;
        #(4*Q);
        chk("rst_strobe", {28'h0, wr_strobe}, 32'h0);

        // Single write to reg1
        clr_scnt(); busy_seen = 1'b0; nack_cnt = 0;
        wr_txn(8'h01, 8'hA5);
        m_out[15:8] = 8'hA5;
        chk("t1_acks", nack_cnt, 0);
        chk("t1_reg1", {24'h0, out_regs[15:8]}, 32'hA5);
        chk("t1_strobe1_cnt", scnt[1], 1);
        chk("t1_other_strobes", scnt[0] + scnt[2] + scnt[3], 0);
        chk("t1_busy_seen", {31'h0, busy_seen}, 32'h1);
        chk("t1_busy_after_stop", {31'h0, busy}, 32'h0);

        // Burst across the R/W -> RO boundary; pointer ends at 5
        clr_scnt(); nack_cnt = 0;
        bus_start(); send(AW); send(8'h03); send(8'h11); send(8'h22); bus_stop();
        m_out[31:24] = 8'h11;
        chk("t2_acks", nack_cnt, 0);
        chk("t2_out_regs", out_regs, m_out);
        chk("t2_strobe3_cnt", scnt[3], 1);
        chk("t2_strobe_total", scnt[0] + scnt[1] + scnt[2] + scnt[3], 1);
        in_regs = 32'h8877_6655;
        rd_burst(1'b0, 8'h00, 1, 1'b0, 32'h0);
        chk("t2_ptr5_read", {24'h0, rd_buf[0]}, 32'h66);

        // Coherent snapshot over a 4-byte burst
        nack_cnt = 0;
        in_regs = 32'h0102_0304;
        rd_burst(1'b1, 8'h04, 4, 1'b1, 32'hFFFF_FFFF);
        chk("t3_acks", nack_cnt, 0);
        chk("t3_byte0", {24'h0, rd_buf[0]}, 32'h04);
        chk("t3_byte1", {24'h0, rd_buf[1]}, 32'h03);
        chk("t3_byte2", {24'h0, rd_buf[2]}, 32'h02);
        chk("t3_byte3", {24'h0, rd_buf[3]}, 32'h01);

        // Table: write one byte, read it back, check strobes and register image
        in_regs = 32'h8877_6655;
        for (int v = 0; v < 6; v++) begin
            clr_scnt(); nack_cnt = 0;
            wr_txn(vt[v].ptr, vt[v].wdat);
            p = int'(vt[v].ptr);
            if (p < 4) m_out[8*p +: 8] = vt[v].wdat;
            rd_burst(1'b1, vt[v].ptr, 1, 1'b0, 32'h0);
            for (int k = 0; k < 4; k++) act_strb[k] = (scnt[k] == 1);
            chk($sformatf("vec%0d_acks", v), nack_cnt, 0);
            chk($sformatf("vec%0d_read", v), {24'h0, rd_buf[0]}, {24'h0, vt[v].exp_rd});
            chk($sformatf("vec%0d_strobe", v), {28'h0, act_strb}, {28'h0, vt[v].exp_strb});
            chk($sformatf("vec%0d_strobe_total", v), scnt[0] + scnt[1] + scnt[2] + scnt[3],
                $countones(vt[v].exp_strb));
            chk($sformatf("vec%0d_out_regs", v), out_regs, m_out);
        end

        // Pointer wrap from last RO register to reg0
        in_regs = 32'hDEAD_BEEF;
        rd_burst(1'b1, 8'h07, 3, 1'b0, 32'h0);
        chk("t4_reg7", {24'h0, rd_buf[0]}, 32'hDE);
        chk("t4_wrap_reg0", {24'h0, rd_buf[1]}, 32'h5A);
        chk("t4_wrap_reg1", {24'h0, rd_buf[2]}, 32'hA5);

        // Foreign address and general call are not acknowledged
        busy_seen = 1'b0;
        bus_start(); tx_byte(8'h92, a); send(8'h55); bus_stop();
        chk("t5_nack_0x49", {31'h0, a}, 32'h0);
        bus_start(); tx_byte(8'h00, a); send(8'h66); bus_stop();
        chk("t5_nack_gencall", {31'h0, a}, 32'h0);
        chk("t5_busy_seen", {31'h0, busy_seen}, 32'h0);
        chk("t5_out_regs", out_regs, m_out);

`ifdef I2C_REGBANK_TIMEOUT_EN
        // SCL held low mid-read while the slave drives a 0
        wr_txn(8'h00, 8'h3C);
        m_out[7:0] = 8'h3C;
        bus_start(); send(AW); send(8'h00); bus_start(); send(AR);
        chk("t6_sda_driven", {31'h0, sda}, 32'h0);
        chk("t6_busy_before", {31'h0, busy}, 32'h1);
        #(40*Q);
        chk("t6_sda_released", {31'h0, sda}, 32'h1);
        chk("t6_busy_cleared", {31'h0, busy}, 32'h0);
        chk("t6_out_regs", out_regs, m_out);
        bus_stop();
`endif

        // Asynchronous reset while the slave drives a data ACK
        bus_start(); send(AW); send(8'h00);
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; #Q;
            m_scl = 1'b1; #(2*Q);
            m_scl = 1'b0; #Q;
        end
        m_sda = 1'b1; #Q;
        m_scl = 1'b1; #Q;
        chk("t7_ack_driven", {31'h0, sda}, 32'h0);
        chk("t7_reg0_written", {24'h0, out_regs[7:0]}, 32'hFF);
        rst = 1'b1;
        #1;
        chk("t7_sda_released", {31'h0, sda}, 32'h1);
        chk("t7_out_regs_reset", out_regs, 32'h0);
        chk("t7_busy_reset", {31'h0, busy}, 32'h0);
        #Q;
        m_scl = 1'b0; #Q;
        rst = 1'b0; #Q;
        bus_stop();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
